// File: rtl/cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : cordic_iter_engine
// Purpose  : Folded circular-coordinate CORDIC engine. A single micro-rotation
//            datapath is reused for ITER clocks per operation. It supports
//            rotation mode (drive z to 0) and vectoring mode (drive y to 0).
//            Results carry the CORDIC gain K (about 1.64676) and are not
//            compensated for it.
// Ports    : CLK        - clock, rising edge
//            RESET_n    - asynchronous active-low reset
//            in_valid   - operands valid      / in_ready  - engine idle
//            mode       - 0 rotation, 1 vectoring (sampled on accept)
//            x_in/y_in/z_in    - Q2.(WIDTH-2) operands, angle in radians
//            out_valid  - result valid        / out_ready - result taken
//            x_out/y_out/z_out - results truncated back to WIDTH
//            busy       - operation in flight or result pending
// Revision : 1.0 - initial release
// ============================================================================
module cordic_iter_engine #(
    parameter int WIDTH = 16,
    parameter int ITER  = 14,
    parameter int EXTRA = 2
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             busy
);

    localparam int IW   = WIDTH + EXTRA;       // internal datapath width
    localparam int FRAC = WIDTH - 2 + EXTRA;   // fractional bits internally
    localparam int CW   = $clog2(ITER);        // iteration counter width

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // atan(2^-i) in radians; only evaluated at elaboration to build the ROM.
    function automatic real atan_pow2(input int i);
        case (i)
            0:       return 0.7853981633974483;
            1:       return 0.4636476090008061;
            2:       return 0.24497866312686414;
            3:       return 0.12435499454676144;
            4:       return 0.06241880999595735;
            5:       return 0.031239833430268277;
            6:       return 0.015623728620476831;
            7:       return 0.007812341060101111;
            8:       return 0.0039062301319669718;
            9:       return 0.0019531225164788188;
            10:      return 0.0009765621895593195;
            11:      return 0.0004882812111948983;
            12:      return 0.00024414062014936177;
            13:      return 0.00012207031189367021;
            14:      return 0.00006103515617420877;
            15:      return 0.000030517578115526096;
            default: return 0.0;
        endcase
    endfunction

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic signed [IW-1:0] r_x, r_y, r_z;
    logic [CW-1:0]        r_iter;
    logic                 r_mode;

    logic [IW-1:0]        w_rom [0:(1<<CW)-1];
    logic signed [IW-1:0] w_x_sh, w_y_sh, w_ang;
    logic signed [IW-1:0] w_x_nxt, w_y_nxt, w_z_nxt;
    logic                 w_d_pos;
    logic                 w_last;

    // Angle ROM, rounded to nearest at the internal precision. The table is
    // padded to a power of two so the counter indexes it without range issues.
    for (genvar k = 0; k < (1 << CW); k++) begin : g_rom
        if (k < ITER) begin : g_used
            localparam int c_ang = $rtoi(atan_pow2(k) * (2.0 ** FRAC) + 0.5);
            assign w_rom[k] = IW'(c_ang);
        end else begin : g_pad
            assign w_rom[k] = '0;
        end
    end

    assign w_last = (r_iter == CW'(ITER - 1));
    assign w_ang  = $signed(w_rom[r_iter]);
    assign w_x_sh = r_x >>> r_iter;
    assign w_y_sh = r_y >>> r_iter;

    // d = +1: rotation drives z toward 0 from above, vectoring lifts a
    // negative y toward 0.
    assign w_d_pos = r_mode ? r_y[IW-1] : ~r_z[IW-1];

    assign w_x_nxt = w_d_pos ? (r_x - w_y_sh) : (r_x + w_y_sh);
    assign w_y_nxt = w_d_pos ? (r_y + w_x_sh) : (r_y - w_x_sh);
    assign w_z_nxt = w_d_pos ? (r_z - w_ang)  : (r_z + w_ang);

    // State register
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) r_state <= c_st_idle;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (in_valid)  w_state_nxt = c_st_run;
            c_st_run:  if (w_last)    w_state_nxt = c_st_done;
            c_st_done: if (out_ready) w_state_nxt = c_st_idle;
            default:                  w_state_nxt = c_st_idle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_iter <= '0;
            r_mode <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_x    <= IW'($signed(x_in)) <<< EXTRA;
                        r_y    <= IW'($signed(y_in)) <<< EXTRA;
                        r_z    <= IW'($signed(z_in)) <<< EXTRA;
                        r_mode <= mode;
                        r_iter <= '0;
                    end
                end
                c_st_run: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    r_z <= w_z_nxt;
                    if (!w_last) r_iter <= r_iter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);

    // Dropping the guard bits is the arithmetic shift right by EXTRA.
    assign x_out = r_x[IW-1:EXTRA];
    assign y_out = r_y[IW-1:EXTRA];
    assign z_out = r_z[IW-1:EXTRA];

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_iter_engine
// Purpose  : Directed self-checking bench for cordic_iter_engine: reset,
//            rotation, vectoring, negative angle, backpressure, asynchronous
//            abort and latency on narrow/short and wide/long configurations.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_iter_engine;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode = 1'b0;
    logic [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] x_out, y_out, z_out;
    logic        busy;

    // ITER=4, WIDTH=12 and ITER=16, WIDTH=24 instances
    logic        v4 = 1'b0, r4, ov4, b4;
    logic [11:0] x4 = '0, y4 = '0, z4 = '0, xo4, yo4, zo4;
    logic        v16 = 1'b0, r16, ov16, b16;
    logic [23:0] x16 = '0, y16 = '0, z16 = '0, xo16, yo16, zo16;
    logic        one = 1'b1, zero = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    cordic_iter_engine #(.WIDTH(16), .ITER(14), .EXTRA(2)) u_dut (
        .CLK(CLK), .RESET_n(RESET_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .busy(busy));

    cordic_iter_engine #(.WIDTH(12), .ITER(4), .EXTRA(2)) u_dut4 (
        .CLK(CLK), .RESET_n(RESET_n), .in_valid(v4), .in_ready(r4),
        .mode(zero), .x_in(x4), .y_in(y4), .z_in(z4),
        .out_valid(ov4), .out_ready(one),
        .x_out(xo4), .y_out(yo4), .z_out(zo4), .busy(b4));

    cordic_iter_engine #(.WIDTH(24), .ITER(16), .EXTRA(2)) u_dut16 (
        .CLK(CLK), .RESET_n(RESET_n), .in_valid(v16), .in_ready(r16),
        .mode(zero), .x_in(x16), .y_in(y16), .z_in(z16),
        .out_valid(ov16), .out_ready(one),
        .x_out(xo16), .y_out(yo16), .z_out(zo16), .busy(b16));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        n_assert++;
        assert ((iabs(obs - exp) <= tol) === 1'b1)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Present operands for one accept edge (engine must be idle).
    task automatic start_op(input logic m, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z);
        mode = m; x_in = x; y_in = y; z_in = z;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin : main
        int n, n4, n16;
        logic [47:0] held;
        logic seen;

        // ---------------- reset state
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_outputs", 32'({x_out, y_out} | 32'(z_out)), 32'd0);
        RESET_n = 1'b1;
        step();

        // ---------------- rotation by pi/6 with 1/K prescale
        start_op(1'b0, 16'h26DD, 16'h0000, 16'h2183);
        check_eq("rot_busy", 32'(busy), 32'd1);
        wait_done(n);
        check_eq("rot_latency", 32'(n), 32'd14);
        check_tol("rot_x_cos", int'($signed(x_out)), 14189, 4);
        check_tol("rot_y_sin", int'($signed(y_out)), 8192, 4);
        check_tol("rot_z_zero", int'($signed(z_out)), 0, 4);
        out_ready = 1'b1;
        step();
        check_eq("rot_release_valid", 32'(out_valid), 32'd0);
        check_eq("rot_release_ready", 32'(in_ready), 32'd1);

        // ---------------- negative angle
        start_op(1'b0, 16'h26DD, 16'h0000, 16'hDE7D);
        wait_done(n);
        check_tol("neg_y_sin", int'($signed(y_out)), -8192, 4);
        check_tol("neg_x_cos", int'($signed(x_out)), 14189, 4);
        step();

        // ---------------- vectoring (0.5, 0.5)
        start_op(1'b1, 16'h2000, 16'h2000, 16'h0000);
        wait_done(n);
        check_eq("vec_latency", 32'(n), 32'd14);
        check_tol("vec_z_pi4", int'($signed(z_out)), 12868, 4);
        check_tol("vec_y_zero", int'($signed(y_out)), 0, 4);
        check_tol("vec_x_mag", int'($signed(x_out)), 19078, 6);
        step();

        // ---------------- backpressure with a new request held throughout
        out_ready = 1'b0;
        start_op(1'b0, 16'h26DD, 16'h0000, 16'h2183);
        wait_done(n);
        held = {x_out, y_out, z_out};
        mode = 1'b1; x_in = 16'h2000; y_in = 16'h2000; z_in = 16'h0000;
        in_valid = 1'b1;
        repeat (5) step();
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_busy", 32'(busy), 32'd1);
        check_eq("bp_stable_hi", 32'(held[47:24]), 32'({x_out, y_out[15:8]}));
        check_eq("bp_stable_lo", 32'(held[23:0]), 32'({y_out[7:0], z_out}));
        out_ready = 1'b1;
        step();
        check_eq("bp_idle_ready", 32'(in_ready), 32'd1);
        check_eq("bp_idle_busy", 32'(busy), 32'd0);
        step();
        in_valid = 1'b0;
        check_eq("bp_accept", 32'(in_ready), 32'd0);
        wait_done(n);
        check_eq("bp_latency", 32'(n), 32'd14);
        check_tol("bp_vec_z", int'($signed(z_out)), 12868, 4);
        step();

        // ---------------- asynchronous reset mid-RUN
        out_ready = 1'b0;
        start_op(1'b0, 16'h26DD, 16'h0000, 16'h2183);
        repeat (3) step();
        #2 RESET_n = 1'b0;
        #1;
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_outputs", 32'({x_out, y_out} | 32'(z_out)), 32'd0);
        #2 RESET_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check_eq("abort_no_stale", 32'(seen), 32'd0);

        // ---------------- parameter sweep: latency and wide-precision result
        x4 = 12'd622; y4 = 12'd0; z4 = 12'd536; v4 = 1'b1;
        x16 = 24'd2547003; y16 = 24'd0; z16 = 24'd2196132; v16 = 1'b1;
        step();
        v4 = 1'b0; v16 = 1'b0;
        n4 = -1; n16 = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ov4 && n4 < 0) n4 = k;
            if (ov16 && n16 < 0) begin
                n16 = k;
                check_tol("w24_y_sin", int'($signed(yo16)), 2097152, 256);
                check_tol("w24_x_cos", int'($signed(xo16)), 3632374, 256);
            end
        end
        check_eq("iter4_latency", 32'(n4), 32'd4);
        check_eq("iter16_latency", 32'(n16), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cordic_iter_engine.md
Name: cordic_iter_engine

Overview:
Folded (iterative) CORDIC engine for circular coordinates, supporting both rotation mode and vectoring mode.
- Successor to the fixed 13-stage, 14-bit, rotation-only pipelined element chain.
- One shared micro-rotation datapath is reused for ITER clocks per operation.
- Operations are framed by valid/ready handshakes on input and output.
- Sits between the stimulus/data source and downstream consumers in the trig/vector-magnitude path.

Parameters:
WIDTH, 16, signed two's-complement width of x, y and z; format Q2.(WIDTH-2). Angle in radians × 2^(WIDTH-2).
ITER, 14, number of micro-rotations, legal range 4..16; iteration index i runs 0..ITER-1.
EXTRA, 2, guard LSBs appended internally to x, y and z; outputs are truncated back to WIDTH.

Ports:
CLK        in   1        clock, rising edge
RESET_n    in   1        asynchronous active-low reset
in_valid   in   1        input operands valid
in_ready   out  1        engine can accept an operation
mode       in   1        0 = rotation, 1 = vectoring; sampled on accept
x_in       in   WIDTH    initial x
y_in       in   WIDTH    initial y
z_in       in   WIDTH    initial angle
out_valid  out  1        result valid
out_ready  in   1        consumer accepts result
x_out      out  WIDTH    final x (carries gain K≈1.64676)
y_out      out  WIDTH    final y
z_out      out  WIDTH    final angle
busy       out  1        high in RUN or DONE state

Behaviour:
- Reset (asynchronous, RESET_n=0):
  - state=IDLE; x/y/z registers, iteration counter and mode register = 0.
  - Outputs: out_valid=0, in_ready=1, busy=0, x_out/y_out/z_out=0.
  - Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE → RUN → DONE → IDLE.
  - IDLE: in_ready=1. When in_valid=1, on the clock edge: load x_in, y_in, z_in (each left-shifted by EXTRA), latch mode, set i=0, go to RUN.
  - RUN: in_ready=0. Each clock performs one micro-rotation with index i, then i←i+1. After the edge where i=ITER-1 completes, go to DONE.
  - DONE: out_valid=1, outputs hold the truncated registers. When out_ready=1 on a clock edge, go to IDLE, out_valid←0.
- Back-to-back operation: in_ready stays 0 in DONE. A new operation is accepted only in IDLE, so there is one bubble cycle minimum between operations.
- Latency: accept edge at cycle 0; out_valid rises after edge ITER (visible cycle ITER+1). If out_ready is held high, throughput is one result per ITER+2 clocks.
- Direction d (+1/-1):
  - Rotation mode: d=+1 if z≥0, else -1.
  - Vectoring mode: d=+1 if y<0, else -1.
- Micro-rotation:
  - x'=x−d·(y>>>i); y'=y+d·(x>>>i); z'=z−d·atan(2^-i).
  - >>> is arithmetic shift; all arithmetic is at WIDTH+EXTRA bits, wrap-around with no saturation.
- Angle ROM: ITER entries of atan(2^-i)·2^(WIDTH-2+EXTRA), rounded to nearest, generated as constants. For EXTRA=0, WIDTH=16: entry0=0x3244, entry1=0x1DAC, entry2=0x0FAE.
- Output truncation: arithmetic right shift by EXTRA.
- Gain: no internal gain compensation. The caller pre-scales by 1/K, or post-scales.
- Convergence domain:
  - Rotation: |z_in| ≤ ~1.74 rad.
  - Vectoring: x_in > 0.
  - Out-of-domain inputs are processed without quadrant correction; the result is undefined but the FSM still completes and handshakes normally.
- Range: |x|, |y| inputs must satisfy magnitude·K < 2, else the result wraps. This is the caller's responsibility.
- Simultaneous events:
  - in_valid during RUN/DONE is ignored; the operands must be held by the source until accepted.
  - out_ready without out_valid has no effect.

Test Plan:
1. Reset: RESET_n asserted asynchronously mid-RUN at a non-edge time → out_valid=0, in_ready=1, outputs 0 immediately; after release, no stale result appears.
2. Rotation (WIDTH=16, ITER=14): x_in=0x26DD (1/K), y_in=0, z_in=0x2183 (π/6), out_ready=1 → after ITER+1 cycles x_out≈0x376D (cos), y_out≈0x2000 (sin), z_out≈0; each within ±4 LSB.
3. Vectoring: x_in=0x2000, y_in=0x2000, z_in=0, mode=1 → z_out≈0x3244 (π/4) ±4, y_out≈0 ±4, x_out≈19078 ±6.
4. Backpressure: out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, busy=1; out_ready=1 → IDLE next edge; an in_valid held throughout is accepted only then.
5. Negative angle: z_in=−0x2183, x_in=0x26DD, y_in=0 → y_out≈0xE000 (−0.5) ±4, x_out≈0x376D ±4.
6. Parameter sweep: ITER=4 and ITER=16, WIDTH=12 and 24 → latency exactly ITER+1; error shrinks monotonically with ITER against a floating-point model.
